// File: rtl/effect_param_controller_if.sv
// Front-panel bundle between the board I/O and effect_param_controller.
//
// Purpose: groups the raw panel inputs (two active-low keys, slide switches)
// with the controller's registered outputs, so that the controller and
// whatever drives the board pins share one port.
//
// Signals:
//   key_dec   1                     decrement key, active low, asynchronous
//   key_inc   1                     increment key, active low, asynchronous
//   SW        10                    slide switches; [SEL_W-1:0] = mode, [9] = restore
//   params    NUM_PARAMS*PARAM_W    packed signed parameters, param i at [i*PARAM_W +: PARAM_W]
//   mode      SEL_W                 registered mode, 0 = bypass
//   upd       1                     one-cycle pulse when any parameter changed
//   at_limit  NUM_PARAMS            bit i set while param i sits at its MIN or MAX
//
// Modports: master = board side (drives keys/switches), slave = controller.
interface effect_param_controller_if #(
    parameter int NUM_PARAMS = 3,
    parameter int PARAM_W    = 32,
    parameter int SEL_W      = 2
);
    logic                          key_dec;
    logic                          key_inc;
    logic [9:0]                    SW;
    logic [NUM_PARAMS*PARAM_W-1:0] params;
    logic [SEL_W-1:0]              mode;
    logic                          upd;
    logic [NUM_PARAMS-1:0]         at_limit;

    modport master (
        output key_dec, key_inc, SW,
        input  params, mode, upd, at_limit
    );

    modport slave (
        input  key_dec, key_inc, SW,
        output params, mode, upd, at_limit
    );
endinterface

// File: rtl/effect_param_controller.sv
// Pushbutton/switch front panel for the effect chain.
//
// Purpose: holds NUM_PARAMS signed effect parameters and edits the one
// selected by the mode switches with two debounced, auto-repeating keys.
// Each parameter has its own MIN/MAX/DEF and either a linear (step 1) or a
// tiered step law. A rising edge on SW[9] restores the selected parameter's
// default. All outputs are registered except at_limit, which is decoded
// from the registered parameter values.
//
// Ports:
//   CLK    in   system clock
//   RST_N  in   synchronous reset, active low
//   panel  slave modport of effect_param_controller_if
//          (key_dec, key_inc, SW in; params, mode, upd, at_limit out)
module effect_param_controller #(
    parameter int                              NUM_PARAMS    = 3,
    parameter int                              PARAM_W       = 32,
    parameter int                              SEL_W         = 2,
    parameter logic [NUM_PARAMS*PARAM_W-1:0]   MIN_VALS      = {32'sd20, 32'sd0, 32'sd1},
    parameter logic [NUM_PARAMS*PARAM_W-1:0]   MAX_VALS      = {32'sd32000, 32'sd255, 32'sd50},
    parameter logic [NUM_PARAMS*PARAM_W-1:0]   DEF_VALS      = {32'sd1000, 32'sd0, 32'sd1},
    parameter logic [NUM_PARAMS-1:0]           TIERED        = 3'b100,
    parameter int                              DEBOUNCE_CYC  = 500000,
    parameter int                              REPEAT_DELAY  = 25000000,
    parameter int                              REPEAT_PERIOD = 5000000
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    effect_param_controller_if.slave  panel
);

    localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE_CYC - 1);
    localparam logic [31:0] HOLD_LAST = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] PER_LAST  = 32'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_HOLD,
        RPT_REPEAT
    } rpt_state_e;

    // ------------------------------------------------------------------
    // Input synchronisers. Only the switch bits that are actually used
    // (mode field and restore) are synchronised.
    // Key index 0 = dec, 1 = inc.
    // ------------------------------------------------------------------
    logic [1:0]       key_s1_q, key_s2_q;
    logic [SEL_W-1:0] sel_s1_q, sel_s2_q;
    logic             rst_s1_q, rst_s2_q;
    logic             rst_prev_q;
    logic [SEL_W-1:0] mode_q;

    logic unused_sw;
    assign unused_sw = ^panel.SW[8:SEL_W];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            key_s1_q   <= '1;
            key_s2_q   <= '1;
            sel_s1_q   <= '1;
            sel_s2_q   <= '1;
            rst_s1_q   <= 1'b1;
            rst_s2_q   <= 1'b1;
            rst_prev_q <= 1'b1;
            mode_q     <= '0;
        end else begin
            key_s1_q   <= {panel.key_inc, panel.key_dec};
            key_s2_q   <= key_s1_q;
            sel_s1_q   <= panel.SW[SEL_W-1:0];
            sel_s2_q   <= sel_s1_q;
            rst_s1_q   <= panel.SW[9];
            rst_s2_q   <= rst_s1_q;
            rst_prev_q <= rst_s2_q;
            mode_q     <= sel_s2_q;
        end
    end

    // Mode is about to change on this edge: any held key stops repeating.
    logic mode_chg;
    assign mode_chg = (sel_s2_q != mode_q);

    logic restore;
    assign restore = rst_s2_q & ~rst_prev_q;

    // ------------------------------------------------------------------
    // Per-key debounce + auto-repeat
    // ------------------------------------------------------------------
    logic [1:0] key_ev;

    for (genvar gi = 0; gi < 2; gi++) begin : g_key
        logic [31:0] deb_cnt_q;
        logic        deb_q;
        logic        press_q;
        rpt_state_e  state_q, state_d;
        logic [31:0] rpt_cnt_q, rpt_cnt_d;
        logic        ev;

        // press_q is a one-cycle pulse after a debounced 1->0 flip.
        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                deb_cnt_q <= '0;
                deb_q     <= 1'b1;
                press_q   <= 1'b0;
            end else begin
                press_q <= 1'b0;
                if (key_s2_q[gi] != deb_q) begin
                    if (deb_cnt_q == DEB_LAST) begin
                        deb_q     <= key_s2_q[gi];
                        deb_cnt_q <= '0;
                        press_q   <= ~key_s2_q[gi];
                    end else begin
                        deb_cnt_q <= deb_cnt_q + 32'd1;
                    end
                end else begin
                    deb_cnt_q <= '0;
                end
            end
        end

        always_comb begin
            state_d   = state_q;
            rpt_cnt_d = rpt_cnt_q;
            ev        = 1'b0;
            case (state_q)
                RPT_IDLE: begin
                    if (press_q && !mode_chg) begin
                        ev        = 1'b1;
                        state_d   = RPT_HOLD;
                        rpt_cnt_d = '0;
                    end
                end
                RPT_HOLD: begin
                    if (deb_q || mode_chg) begin
                        state_d = RPT_IDLE;
                    end else if (rpt_cnt_q == HOLD_LAST) begin
                        ev        = 1'b1;
                        state_d   = RPT_REPEAT;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 32'd1;
                    end
                end
                RPT_REPEAT: begin
                    if (deb_q || mode_chg) begin
                        state_d = RPT_IDLE;
                    end else if (rpt_cnt_q == PER_LAST) begin
                        ev        = 1'b1;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 32'd1;
                    end
                end
                default: state_d = RPT_IDLE;
            endcase
        end

        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                state_q   <= RPT_IDLE;
                rpt_cnt_q <= '0;
            end else begin
                state_q   <= state_d;
                rpt_cnt_q <= rpt_cnt_d;
            end
        end

        assign key_ev[gi] = ev;
    end

    // Simultaneous inc and dec events cancel each other.
    logic do_inc, do_dec;
    assign do_inc = key_ev[1] & ~key_ev[0];
    assign do_dec = key_ev[0] & ~key_ev[1];

    // Step size for value v; the dec thresholds are inclusive so that
    // inc followed by dec returns to the same value at tier boundaries.
    function automatic logic signed [PARAM_W:0] step_size(
        input logic signed [PARAM_W-1:0] v,
        input logic                      up,
        input logic                      tiered
    );
        if (!tiered)                      return (PARAM_W+1)'(1);
        else if (up) begin
            if (v < 100)                  return (PARAM_W+1)'(10);
            else if (v < 500)             return (PARAM_W+1)'(50);
            else if (v < 1000)            return (PARAM_W+1)'(100);
            else                          return (PARAM_W+1)'(500);
        end else begin
            if (v <= 100)                 return (PARAM_W+1)'(10);
            else if (v <= 500)            return (PARAM_W+1)'(50);
            else if (v <= 1000)           return (PARAM_W+1)'(100);
            else                          return (PARAM_W+1)'(500);
        end
    endfunction

    // ------------------------------------------------------------------
    // Parameter registers
    // ------------------------------------------------------------------
    logic [NUM_PARAMS*PARAM_W-1:0] params_flat;
    logic [NUM_PARAMS-1:0]         param_changed;
    logic [NUM_PARAMS-1:0]         at_limit_vec;

    for (genvar gi = 0; gi < NUM_PARAMS; gi++) begin : g_param
        localparam logic signed [PARAM_W-1:0] P_MIN = MIN_VALS[gi*PARAM_W +: PARAM_W];
        localparam logic signed [PARAM_W-1:0] P_MAX = MAX_VALS[gi*PARAM_W +: PARAM_W];
        localparam logic signed [PARAM_W-1:0] P_DEF = DEF_VALS[gi*PARAM_W +: PARAM_W];
        localparam logic signed [PARAM_W:0]   MIN_X = {P_MIN[PARAM_W-1], P_MIN};
        localparam logic signed [PARAM_W:0]   MAX_X = {P_MAX[PARAM_W-1], P_MAX};

        logic signed [PARAM_W-1:0] val_q, val_d;
        logic signed [PARAM_W:0]   val_x, stp, raw;

        // The arithmetic is one bit wider than the parameter so the
        // saturation compare sees the true result instead of a wrapped one.
        always_comb begin
            val_d = val_q;
            val_x = {val_q[PARAM_W-1], val_q};
            stp   = step_size(val_q, do_inc, TIERED[gi]);
            raw   = do_inc ? (val_x + stp) : (val_x - stp);
            if (mode_q == SEL_W'(gi + 1)) begin
                if (restore) begin
                    val_d = P_DEF;
                end else if (do_inc || do_dec) begin
                    if (raw > MAX_X)      val_d = P_MAX;
                    else if (raw < MIN_X) val_d = P_MIN;
                    else                  val_d = raw[PARAM_W-1:0];
                end
            end
        end

        always_ff @(posedge CLK) begin
            if (!RST_N) val_q <= P_DEF;
            else        val_q <= val_d;
        end

        assign param_changed[gi]                    = (val_d != val_q);
        assign params_flat[gi*PARAM_W +: PARAM_W]   = val_q;
        assign at_limit_vec[gi]                     = (val_q == P_MIN) || (val_q == P_MAX);
    end

    // upd goes high in the same cycle the new value appears on params.
    logic upd_q;
    always_ff @(posedge CLK) begin
        if (!RST_N) upd_q <= 1'b0;
        else        upd_q <= |param_changed;
    end

    assign panel.params   = params_flat;
    assign panel.mode     = mode_q;
    assign panel.upd      = upd_q;
    assign panel.at_limit = at_limit_vec;

endmodule

// File: tb/tb_effect_param_controller.sv
module tb_effect_param_controller;

    localparam int NP = 3;
    localparam int DC = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    localparam int MINV [3] = '{1, 0, 20};
    localparam int MAXV [3] = '{50, 255, 32000};
    localparam int DEFV [3] = '{1, 0, 1000};
    localparam bit TIER [3] = '{1'b0, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    effect_param_controller_if #(.NUM_PARAMS(3), .PARAM_W(32), .SEL_W(2)) bus ();

    effect_param_controller #(
        .DEBOUNCE_CYC (DC),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .panel(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: keys are described by how long they have been held
    // since the debounced press (age), not by a repeat state machine.
    // ------------------------------------------------------------------
    int         m_p [3];
    logic [1:0] m_mode;
    bit         m_upd;
    bit [1:0]   m_ks1, m_ks2, m_deb, m_act;
    int         m_run [2];
    int         m_age [2];
    logic [9:0] m_sw1, m_sw2;
    bit         m_sw9p;
    bit         m_started = 1'b0;

    function automatic int next_val(input int v, input bit up, input int idx);
        longint n;
        int     s;
        if (!TIER[idx])    s = 1;
        else if (up)       s = (v < 100) ? 10 : (v < 500) ? 50 : (v < 1000) ? 100 : 500;
        else               s = (v <= 100) ? 10 : (v <= 500) ? 50 : (v <= 1000) ? 100 : 500;
        n = up ? longint'(v) + s : longint'(v) - s;
        if (n > MAXV[idx]) n = MAXV[idx];
        if (n < MINV[idx]) n = MINV[idx];
        return int'(n);
    endfunction

    task automatic model_step();
        bit       ev [2];
        bit       mchg, rest;
        int       t;
        int       np [3];
        bit [1:0] kraw;
        if (!rst_n) begin
            for (int i = 0; i < NP; i++) m_p[i] = DEFV[i];
            m_mode = 2'd0; m_upd = 1'b0;
            m_ks1 = 2'b11; m_ks2 = 2'b11; m_deb = 2'b11; m_act = 2'b00;
            m_run[0] = 0; m_run[1] = 0; m_age[0] = 0; m_age[1] = 0;
            m_sw1 = '1; m_sw2 = '1; m_sw9p = 1'b1;
        end else begin
            mchg = (m_sw2[1:0] != m_mode);
            for (int k = 0; k < 2; k++) begin
                ev[k] = 1'b0;
                if (m_act[k]) begin
                    m_age[k]++;
                    if (m_age[k] == 1 || (m_age[k] >= 1 + RD && (m_age[k] - 1 - RD) % RP == 0))
                        ev[k] = 1'b1;
                end
                if (mchg) begin
                    ev[k] = 1'b0;
                    m_act[k] = 1'b0;
                end
            end
            rest = m_sw2[9] && !m_sw9p;
            np = m_p;
            if (m_mode >= 1 && m_mode <= NP) begin
                t = int'(m_mode) - 1;
                if (rest)                   np[t] = DEFV[t];
                else if (ev[1] && !ev[0])   np[t] = next_val(m_p[t], 1'b1, t);
                else if (ev[0] && !ev[1])   np[t] = next_val(m_p[t], 1'b0, t);
            end
            m_upd = 1'b0;
            for (int i = 0; i < NP; i++) if (np[i] != m_p[i]) m_upd = 1'b1;
            m_p = np;
            // A key level counts once the synchronised level has disagreed
            // with the accepted one for DC consecutive cycles.
            kraw = {bus.key_inc, bus.key_dec};
            for (int k = 0; k < 2; k++) begin
                if (m_ks2[k] != m_deb[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DC) begin
                        m_deb[k] = m_ks2[k];
                        m_run[k] = 0;
                        m_act[k] = !m_deb[k];
                        m_age[k] = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            m_ks2  = m_ks1;
            m_ks1  = kraw;
            m_sw9p = m_sw2[9];
            m_mode = m_sw2[1:0];
            m_sw2  = m_sw1;
            m_sw1  = bus.SW;
        end
        m_started = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Cycle-by-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (m_started) begin
            for (int i = 0; i < NP; i++)
                check($sformatf("param%0d", i), longint'($signed(bus.params[i*32 +: 32])), longint'(m_p[i]));
            check("mode", longint'(bus.mode), longint'(m_mode));
            check("upd", longint'(bus.upd), longint'(m_upd));
            for (int i = 0; i < NP; i++)
                check($sformatf("at_limit%0d", i), longint'(bus.at_limit[i]),
                      longint'((m_p[i] == MINV[i]) || (m_p[i] == MAXV[i])));
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed checkpoints
    // ------------------------------------------------------------------
    function automatic int dut_p(input int i);
        return int'($signed(bus.params[i*32 +: 32]));
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit inc, input int n);
        if (inc) bus.key_inc = 1'b0; else bus.key_dec = 1'b0;
        cyc(n);
        bus.key_inc = 1'b1;
        bus.key_dec = 1'b1;
        cyc(12);
    endtask

    task automatic set_sw(input logic [9:0] v);
        bus.SW = v;
        cyc(8);
    endtask

    initial begin
        bus.key_dec = 1'b1;
        bus.key_inc = 1'b1;
        bus.SW      = 10'd0;
        rst_n       = 1'b0;
        cyc(5);
        // Reset state
        check("rst_gain", dut_p(0), 1);
        check("rst_drive", dut_p(1), 0);
        check("rst_thresh", dut_p(2), 1000);
        check("rst_mode", bus.mode, 0);
        check("rst_upd", bus.upd, 0);
        rst_n = 1'b1;
        cyc(6);
        $display("reset released: params %0d %0d %0d", dut_p(0), dut_p(1), dut_p(2));

        // Mode 1: glitch ignored, clean press steps once
        set_sw(10'd1);
        press(1'b1, 3);
        check("glitch_gain", dut_p(0), 1);
        $display("glitch press: gain=%0d", dut_p(0));
        press(1'b1, 10);
        check("press_gain", dut_p(0), 2);
        $display("single press: gain=%0d", dut_p(0));

        // Long hold saturates at MAX
        press(1'b1, 420);
        check("hold_gain", dut_p(0), 50);
        check("hold_limit", bus.at_limit[0], 1);
        $display("long hold inc: gain=%0d at_limit=%b", dut_p(0), bus.at_limit);

        // Mode 2 linear
        set_sw(10'd2);
        press(1'b1, 10);
        check("drive_inc", dut_p(1), 1);
        $display("mode 2 inc: drive=%0d", dut_p(1));

        // Mode 3 tiered
        set_sw(10'd3);
        press(1'b0, 10);
        check("thr_dec1000", dut_p(2), 900);
        $display("mode 3 dec: thresh=%0d", dut_p(2));
        press(1'b0, 260);
        check("thr_min", dut_p(2), 20);
        check("thr_limit", bus.at_limit[2], 1);
        $display("long hold dec: thresh=%0d", dut_p(2));
        press(1'b1, 10);
        check("thr_inc20", dut_p(2), 30);
        for (int i = 0; i < 7; i++) press(1'b1, 10);
        check("thr_to100", dut_p(2), 100);
        press(1'b1, 10);
        check("thr_inc100", dut_p(2), 150);
        $display("tiered inc: thresh=%0d", dut_p(2));

        // Both keys together: no change
        bus.key_inc = 1'b0;
        bus.key_dec = 1'b0;
        cyc(10);
        bus.key_inc = 1'b1;
        bus.key_dec = 1'b1;
        cyc(12);
        check("both_keys", dut_p(2), 150);
        $display("both keys: thresh=%0d", dut_p(2));

        // Restore default via SW[9] rise
        press(1'b0, 150);
        check("thr_min2", dut_p(2), 20);
        set_sw(10'h203);
        check("restore_thr", dut_p(2), 1000);
        $display("restore mode 3: thresh=%0d", dut_p(2));
        set_sw(10'd1);
        set_sw(10'h201);
        set_sw(10'd1);
        check("restore_gain", dut_p(0), 1);
        $display("restore mode 1: gain=%0d", dut_p(0));

        // Hold in mode 1, switch to bypass: repeats stop
        bus.key_inc = 1'b0;
        cyc(30);
        bus.SW = 10'd0;
        cyc(100);
        check("bypass_gain", dut_p(0), 3);
        check("bypass_mode", bus.mode, 0);
        bus.key_inc = 1'b1;
        cyc(12);
        press(1'b0, 10);
        check("bypass_dec", dut_p(0), 3);
        check("bypass_drive", dut_p(1), 1);
        check("bypass_thr", dut_p(2), 1000);
        $display("bypass: params %0d %0d %0d", dut_p(0), dut_p(1), dut_p(2));

        // Reset in the middle of an auto-repeat
        set_sw(10'd1);
        bus.key_inc = 1'b0;
        cyc(40);
        check("pre_reset_gain", dut_p(0), 6);
        rst_n = 1'b0;
        cyc(1);
        check("midrst_gain", dut_p(0), 1);
        check("midrst_drive", dut_p(1), 0);
        check("midrst_thr", dut_p(2), 1000);
        check("midrst_mode", bus.mode, 0);
        $display("mid-repeat reset: params %0d %0d %0d", dut_p(0), dut_p(1), dut_p(2));
        bus.key_inc = 1'b1;
        rst_n = 1'b1;
        cyc(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
